keypad_scanner: RTL

- Upstream input stage for the calculator state machine.
- Scans a 4x4 active-low key matrix, synchronises and debounces the row lines, and decodes the pressed key.
- Emits exactly one single-cycle key event per physical press; the calculator FSM consumes these events to build operands and the operator.

---
 rtl/calc_pkg.sv | 97 +++++++++
 rtl/keypad_scanner_tick_gen.sv | 32 +++
 rtl/keypad_scanner.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator datapath and its keypad front end.
// Contents:
//   KEY_*          4-bit key codes produced by the keypad scanner
//   key_class_t    class of a key: digit / operator / equals / clear
//   scan_state_t   keypad scanner FSM state encoding
//   key_lookup     (row, col) -> key code for the 4x4 matrix
//   key_classify   key code -> key class
//   lowest_low_row index of the lowest-numbered row pulled low
package calc_pkg;

  localparam logic [3:0] KEY_0   = 4'h0;
  localparam logic [3:0] KEY_1   = 4'h1;
  localparam logic [3:0] KEY_2   = 4'h2;
  localparam logic [3:0] KEY_3   = 4'h3;
  localparam logic [3:0] KEY_4   = 4'h4;
  localparam logic [3:0] KEY_5   = 4'h5;
  localparam logic [3:0] KEY_6   = 4'h6;
  localparam logic [3:0] KEY_7   = 4'h7;
  localparam logic [3:0] KEY_8   = 4'h8;
  localparam logic [3:0] KEY_9   = 4'h9;
  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_MUL = 4'hC;
  localparam logic [3:0] KEY_DIV = 4'hD;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef enum logic [1:0] {
    CLASS_DIGIT = 2'd0,
    CLASS_OP    = 2'd1,
    CLASS_EQ    = 2'd2,
    CLASS_CLR   = 2'd3
  } key_class_t;

  typedef enum logic [2:0] {
    SCAN         = 3'd0,
    DEBOUNCE     = 3'd1,
    PRESS        = 3'd2,
    WAIT_RELEASE = 3'd3,
    REL_DEBOUNCE = 3'd4
  } scan_state_t;

  // Physical keypad layout:
  //   r0: 1 2 3 +
  //   r1: 4 5 6 -
  //   r2: 7 8 9 *
  //   r3: C 0 = /
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = KEY_1;
      4'b00_01: code = KEY_2;
      4'b00_10: code = KEY_3;
      4'b00_11: code = KEY_ADD;
      4'b01_00: code = KEY_4;
      4'b01_01: code = KEY_5;
      4'b01_10: code = KEY_6;
      4'b01_11: code = KEY_SUB;
      4'b10_00: code = KEY_7;
      4'b10_01: code = KEY_8;
      4'b10_10: code = KEY_9;
      4'b10_11: code = KEY_MUL;
      4'b11_00: code = KEY_CLR;
      4'b11_01: code = KEY_0;
      4'b11_10: code = KEY_EQ;
      default:  code = KEY_DIV;
    endcase
    return code;
  endfunction

  function automatic key_class_t key_classify(input logic [3:0] code);
    key_class_t cls;
    if (code <= KEY_9)
      cls = CLASS_DIGIT;
    else if (code == KEY_EQ)
      cls = CLASS_EQ;
    else if (code == KEY_CLR)
      cls = CLASS_CLR;
    else
      cls = CLASS_OP;
    return cls;
  endfunction

  // Rows are active-low; the lowest index wins when several are closed.
  // Callers only use the result when at least one row is low.
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    casez (rows)
      4'b???0: idx = 2'd0;
      4'b??01: idx = 2'd1;
      4'b?011: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Scan-rate tick generator for the keypad scanner.
// A free-running counter 0..CLK_DIV-1; tick is high for the one cycle in
// which the counter sits at its last value, i.e. the cycle before it wraps.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   tick   one-cycle pulse every CLK_DIV clocks
module tick_gen #(
  parameter int CLK_DIV = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt_reg <= '0;
    else if (tick)
      cnt_reg <= '0;
    else
      cnt_reg <= cnt_reg + CNT_W'(1);
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner feeding the calculator FSM.
// Drives one column low at a time, synchronises the rows through two flops,
// debounces press and release over DEBOUNCE_TICKS scan ticks and emits one
// single-cycle key event per physical press.
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   row_in     matrix rows (pulled up, 0 = key closed on driven column)
//   col_out    one-cold column drive
//   key_valid  one-cycle pulse per accepted press
//   key_code   decoded key, held until the next event
//   key_class  0 digit, 1 operator, 2 equals, 3 clear
//   key_busy   high from press detection until release is confirmed
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int CLK_DIV        = 1000,
  parameter int DEBOUNCE_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [1:0] key_class,
  output logic       key_busy
);

  localparam int DB_W = $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TICKS - 1);

  logic tick;

  tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Two-flop synchroniser; idle value is "no key" (all ones).
  logic [3:0] row_meta_reg;
  logic [3:0] row_s_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_reg <= 4'hF;
      row_s_reg    <= 4'hF;
    end else begin
      row_meta_reg <= row_in;
      row_s_reg    <= row_meta_reg;
    end
  end

  scan_state_t      state_reg,     state_next;
  logic [1:0]       col_idx_reg,   col_idx_next;
  logic [1:0]       cand_row_reg,  cand_row_next;
  logic [DB_W-1:0]  db_cnt_reg,    db_cnt_next;
  logic [3:0]       key_code_reg,  key_code_next;
  key_class_t       key_class_reg, key_class_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= SCAN;
      col_idx_reg   <= 2'd0;
      cand_row_reg  <= 2'd0;
      db_cnt_reg    <= '0;
      key_code_reg  <= KEY_0;
      key_class_reg <= CLASS_DIGIT;
    end else begin
      state_reg     <= state_next;
      col_idx_reg   <= col_idx_next;
      cand_row_reg  <= cand_row_next;
      db_cnt_reg    <= db_cnt_next;
      key_code_reg  <= key_code_next;
      key_class_reg <= key_class_next;
    end
  end

  logic       row_any_low;
  logic [1:0] row_low_idx;
  logic       cand_high;

  assign row_any_low = (row_s_reg != 4'hF);
  assign row_low_idx = lowest_low_row(row_s_reg);
  assign cand_high   = row_s_reg[cand_row_reg];

  always_comb begin
    state_next     = state_reg;
    col_idx_next   = col_idx_reg;
    cand_row_next  = cand_row_reg;
    db_cnt_next    = db_cnt_reg;
    key_code_next  = key_code_reg;
    key_class_next = key_class_reg;

    case (state_reg)
      SCAN: begin
        if (tick) begin
          if (!row_any_low) begin
            col_idx_next = col_idx_reg + 2'd1;
          end else begin
            cand_row_next = row_low_idx;
            db_cnt_next   = DB_ONE;
            if (DEBOUNCE_TICKS == 1) begin
              // The detecting tick already satisfies a one-tick debounce.
              state_next     = PRESS;
              key_code_next  = key_lookup(row_low_idx, col_idx_reg);
              key_class_next = key_classify(key_lookup(row_low_idx, col_idx_reg));
            end else begin
              state_next = DEBOUNCE;
            end
          end
        end
      end

      DEBOUNCE: begin
        if (tick) begin
          if (row_any_low && (row_low_idx == cand_row_reg)) begin
            db_cnt_next = db_cnt_reg + DB_ONE;
            if (db_cnt_reg == DB_LAST) begin
              // Code is latched on entry so it is already valid in the PRESS cycle.
              state_next     = PRESS;
              key_code_next  = key_lookup(cand_row_reg, col_idx_reg);
              key_class_next = key_classify(key_lookup(cand_row_reg, col_idx_reg));
            end
          end else begin
            // Abort without advancing: the same column is re-examined next tick.
            state_next = SCAN;
          end
        end
      end

      PRESS: begin
        state_next = WAIT_RELEASE;
      end

      WAIT_RELEASE: begin
        if (tick && cand_high) begin
          db_cnt_next = DB_ONE;
          state_next  = (DEBOUNCE_TICKS == 1) ? SCAN : REL_DEBOUNCE;
        end
      end

      REL_DEBOUNCE: begin
        if (tick) begin
          if (!cand_high) begin
            state_next = WAIT_RELEASE;
          end else begin
            db_cnt_next = db_cnt_reg + DB_ONE;
            if (db_cnt_reg == DB_LAST)
              state_next = SCAN;
          end
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // One-cold column drive straight from the column index register.
  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    assign col_out[gi] = (col_idx_reg != 2'(gi));
  end

  assign key_valid = (state_reg == PRESS);
  assign key_busy  = (state_reg != SCAN);
  assign key_code  = key_code_reg;
  assign key_class = key_class_reg;

endmodule
